// File: rtl/enm_hp_ctrl_pkg.sv
// Shared widths, FSM state type and default tuning constants for the enemy HP controller.
package enm_pkg;

  localparam int HP_W    = 7;
  localparam int COORD_W = 10;

  localparam int DEF_HP_INIT  = 100;
  localparam int DEF_DMG      = 10;
  localparam int DEF_HIT_W    = 16;
  localparam int DEF_HIT_H    = 16;
  localparam int DEF_COOLDOWN = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    CLEAR = 2'd2
  } enm_state_e;

endpackage

// File: rtl/enm_hp_ctrl_if.sv
// Bullet/enemy bus between the game logic and enm_hp_ctrl.
// The score signal exists only when ENM_HP_SCORE_EN is defined.
interface enm_hp_ctrl_if;
  import enm_pkg::*;

  logic               start;
  logic               bullet_vld;
  logic [COORD_W-1:0] bullet_x, bullet_y;
  logic [COORD_W-1:0] enmx1, enmx2, enmx3, enmx4;
  logic [COORD_W-1:0] enmy1, enmy2, enmy3, enmy4;
  logic [HP_W-1:0]    enmhp1, enmhp2, enmhp3, enmhp4;
  logic               bullet_hit;
  logic [1:0]         hit_id;
  logic               all_clear;
  logic               playing;
`ifdef ENM_HP_SCORE_EN
  logic [15:0]        score;
`endif

  modport master (
    output start, bullet_vld, bullet_x, bullet_y,
    output enmx1, enmx2, enmx3, enmx4, enmy1, enmy2, enmy3, enmy4,
    input  enmhp1, enmhp2, enmhp3, enmhp4, bullet_hit, hit_id, all_clear, playing
`ifdef ENM_HP_SCORE_EN
    , input score
`endif
  );

  modport slave (
    input  start, bullet_vld, bullet_x, bullet_y,
    input  enmx1, enmx2, enmx3, enmx4, enmy1, enmy2, enmy3, enmy4,
    output enmhp1, enmhp2, enmhp3, enmhp4, bullet_hit, hit_id, all_clear, playing
`ifdef ENM_HP_SCORE_EN
    , output score
`endif
  );

endinterface

// File: rtl/enm_hp_ctrl_hit_box.sv
// Combinational overlap test of one bullet centre against one enemy hit box.
module enm_hit_box
  import enm_pkg::*;
#(
  parameter int HALF_W = DEF_HIT_W,
  parameter int HALF_H = DEF_HIT_H
) (
  input  logic [COORD_W-1:0] bx_i,
  input  logic [COORD_W-1:0] by_i,
  input  logic [COORD_W-1:0] ex_i,
  input  logic [COORD_W-1:0] ey_i,
  output logic               inside_o
);

  localparam logic [COORD_W:0] HW_L = (COORD_W+1)'(HALF_W);
  localparam logic [COORD_W:0] HH_L = (COORD_W+1)'(HALF_H);

  logic [COORD_W-1:0] dx, dy;

  // max - min keeps the distance from wrapping near the screen edges
  always_comb begin
    dx       = (bx_i >= ex_i) ? (bx_i - ex_i) : (ex_i - bx_i);
    dy       = (by_i >= ey_i) ? (by_i - ey_i) : (ey_i - by_i);
    inside_o = ({1'b0, dx} < HW_L) && ({1'b0, dy} < HH_L);
  end

endmodule

// File: rtl/enm_hp_ctrl.sv
// Enemy HP registers, hit arbitration, per-enemy cooldown and wave FSM (IDLE/PLAY/CLEAR).
// Optional score counter enabled by defining ENM_HP_SCORE_EN.
module enm_hp_ctrl
  import enm_pkg::*;
#(
  parameter int HP_INIT  = DEF_HP_INIT,
  parameter int DMG      = DEF_DMG,
  parameter int HIT_W    = DEF_HIT_W,
  parameter int HIT_H    = DEF_HIT_H,
  parameter int COOLDOWN = DEF_COOLDOWN
) (
  input  logic          clk22,
  input  logic          rst,
  enm_hp_ctrl_if.slave  bus
);

  localparam int CD_W = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [HP_W-1:0] HP_INIT_L = HP_W'(HP_INIT);
  localparam logic [HP_W-1:0] DMG_L     = HP_W'(DMG);
  localparam logic [CD_W-1:0] CD_L      = CD_W'(COOLDOWN);

  enm_state_e state_q, state_d;

  logic [HP_W-1:0]    hp_q [4];
  logic [HP_W-1:0]    hp_d [4];
  logic [CD_W-1:0]    cd_q [4];
  logic [CD_W-1:0]    cd_d [4];
  logic               hit_q, hit_d;
  logic [1:0]         id_q, id_d;
  logic [1:0]         sel;
  logic               load, all_dead;
  logic [3:0]         inbox, cand;
  logic [COORD_W-1:0] ex [4];
  logic [COORD_W-1:0] ey [4];

  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp);
    return (hp <= DMG_L) ? '0 : (hp - DMG_L);
  endfunction

  assign ex[0] = bus.enmx1;
  assign ex[1] = bus.enmx2;
  assign ex[2] = bus.enmx3;
  assign ex[3] = bus.enmx4;
  assign ey[0] = bus.enmy1;
  assign ey[1] = bus.enmy2;
  assign ey[2] = bus.enmy3;
  assign ey[3] = bus.enmy4;

  for (genvar g = 0; g < 4; g++) begin : g_box
    enm_hit_box #(.HALF_W(HIT_W), .HALF_H(HIT_H)) u_box (
      .bx_i     (bus.bullet_x),
      .by_i     (bus.bullet_y),
      .ex_i     (ex[g]),
      .ey_i     (ey[g]),
      .inside_o (inbox[g])
    );
  end

  assign load     = (state_q != PLAY) && bus.start;
  assign all_dead = ((hp_q[0] | hp_q[1] | hp_q[2] | hp_q[3]) == '0);

  always_ff @(posedge clk22) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = PLAY;
      PLAY:    if (all_dead)  state_d = CLEAR;
      CLEAR:   if (bus.start) state_d = PLAY;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.playing   = (state_q == PLAY);
    bus.all_clear = (state_q == CLEAR);
  end

  // Lowest-index candidate wins; only one enemy is damaged per tick
  always_comb begin
    sel = '0;
    for (int i = 0; i < 4; i++)
      cand[i] = (state_q == PLAY) && bus.bullet_vld && (hp_q[i] != '0) &&
                (cd_q[i] == '0) && inbox[i];
    for (int i = 3; i >= 0; i--)
      if (cand[i]) sel = 2'(i);
    hit_d = |cand;
    id_d  = id_q;
    for (int i = 0; i < 4; i++) begin
      hp_d[i] = hp_q[i];
      cd_d[i] = (cd_q[i] != '0) ? (cd_q[i] - 1'b1) : '0;
    end
    if (load) begin
      for (int i = 0; i < 4; i++) begin
        hp_d[i] = HP_INIT_L;
        cd_d[i] = '0;
      end
    end else if (hit_d) begin
      hp_d[sel] = sat_sub(hp_q[sel]);
      cd_d[sel] = CD_L;
      id_d      = sel;
    end
  end

  always_ff @(posedge clk22) begin
    if (rst) begin
      hit_q <= 1'b0;
      id_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        hp_q[i] <= '0;
        cd_q[i] <= '0;
      end
    end else begin
      hit_q <= hit_d;
      id_q  <= id_d;
      for (int i = 0; i < 4; i++) begin
        hp_q[i] <= hp_d[i];
        cd_q[i] <= cd_d[i];
      end
    end
  end

  assign bus.enmhp1     = hp_q[0];
  assign bus.enmhp2     = hp_q[1];
  assign bus.enmhp3     = hp_q[2];
  assign bus.enmhp4     = hp_q[3];
  assign bus.bullet_hit = hit_q;
  assign bus.hit_id     = id_q;

`ifdef ENM_HP_SCORE_EN
  logic [15:0] score_q, score_d;

  function automatic logic [15:0] sat_add(input logic [15:0] s, input logic [15:0] inc);
    logic [16:0] sum;
    sum = {1'b0, s} + {1'b0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  // A restart from CLEAR keeps the running score; only a fresh game clears it
  always_comb begin
    score_d = score_q;
    if ((state_q == IDLE) && bus.start)
      score_d = '0;
    else if (hit_d)
      score_d = sat_add(score_q, (sat_sub(hp_q[sel]) == '0) ? 16'd11 : 16'd1);
  end

  always_ff @(posedge clk22) begin
    if (rst) score_q <= '0;
    else     score_q <= score_d;
  end

  assign bus.score = score_q;
`endif

endmodule

// File: tb/tb_enm_hp_ctrl.sv
// Scoreboard bench for enm_hp_ctrl: randomized ticks against an integer reference model.
module tb_enm_hp_ctrl;

  localparam int TB_HP_INIT  = 95;
  localparam int TB_DMG      = 10;
  localparam int TB_HIT_W    = 16;
  localparam int TB_HIT_H    = 16;
  localparam int TB_COOLDOWN = 4;

  typedef struct {
    int hp [4];
    int hit;
    int id;
    int clr;
    int ply;
    int score;
  } exp_t;

  logic clk22 = 1'b0;
  logic rst   = 1'b1;
  always #5 clk22 = ~clk22;

  enm_hp_ctrl_if bus_if ();

  enm_hp_ctrl #(.HP_INIT(TB_HP_INIT)) dut (
    .clk22 (clk22),
    .rst   (rst),
    .bus   (bus_if)
  );

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  int ex [4];
  int ey [4];
  int m_hp [4];
  int m_cd [4];
  int m_st;      // 0 idle, 1 play, 2 clear
  int m_id;
  int m_score;

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit s, input bit v, input int bx, input int by);
    exp_t e;
    int   hit;
    int   nst;
    bit   dead;
    hit = -1;
    if (r) begin
      m_st = 0; m_id = 0; m_score = 0;
      for (int i = 0; i < 4; i++) begin m_hp[i] = 0; m_cd[i] = 0; end
    end else begin
      nst  = m_st;
      dead = (m_st == 1) && (m_hp[0] + m_hp[1] + m_hp[2] + m_hp[3] == 0);
      if (m_st == 1 && v)
        for (int i = 0; i < 4; i++)
          if (hit < 0 && m_hp[i] > 0 && m_cd[i] == 0 &&
              absd(bx, ex[i]) < TB_HIT_W && absd(by, ey[i]) < TB_HIT_H)
            hit = i;
      for (int i = 0; i < 4; i++) if (m_cd[i] > 0) m_cd[i]--;
      if (m_st != 1 && s) begin
        if (m_st == 0) m_score = 0;
        for (int i = 0; i < 4; i++) begin m_hp[i] = TB_HP_INIT; m_cd[i] = 0; end
        nst = 1;
      end else if (dead) begin
        nst = 2;
      end
      if (hit >= 0) begin
        m_hp[hit] = (m_hp[hit] - TB_DMG < 0) ? 0 : m_hp[hit] - TB_DMG;
        m_cd[hit] = TB_COOLDOWN;
        m_id      = hit;
        m_score   = m_score + 1 + ((m_hp[hit] == 0) ? 10 : 0);
        if (m_score > 65535) m_score = 65535;
      end
      m_st = nst;
    end
    for (int i = 0; i < 4; i++) e.hp[i] = m_hp[i];
    e.hit   = (hit >= 0) ? 1 : 0;
    e.id    = m_id;
    e.clr   = (m_st == 2) ? 1 : 0;
    e.ply   = (m_st == 1) ? 1 : 0;
    e.score = m_score;
    exp_q.push_back(e);
  endtask

  // One tick of stimulus; the expected post-edge outputs go to the scoreboard
  task automatic drive(input bit r, input bit s, input bit v, input int bx, input int by);
    @(negedge clk22);
    rst               = r;
    bus_if.start      = s;
    bus_if.bullet_vld = v;
    bus_if.bullet_x   = 10'(bx);
    bus_if.bullet_y   = 10'(by);
    bus_if.enmx1 = 10'(ex[0]); bus_if.enmy1 = 10'(ey[0]);
    bus_if.enmx2 = 10'(ex[1]); bus_if.enmy2 = 10'(ey[1]);
    bus_if.enmx3 = 10'(ex[2]); bus_if.enmy3 = 10'(ey[2]);
    bus_if.enmx4 = 10'(ex[3]); bus_if.enmy4 = 10'(ey[3]);
    model_step(r, s, v, bx, by);
  endtask

  always begin
    exp_t e;
    @(posedge clk22);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("enmhp1", 32'(bus_if.enmhp1), e.hp[0]);
      chk("enmhp2", 32'(bus_if.enmhp2), e.hp[1]);
      chk("enmhp3", 32'(bus_if.enmhp3), e.hp[2]);
      chk("enmhp4", 32'(bus_if.enmhp4), e.hp[3]);
      chk("bullet_hit", 32'(bus_if.bullet_hit), e.hit);
      chk("hit_id", 32'(bus_if.hit_id), e.id);
      chk("all_clear", 32'(bus_if.all_clear), e.clr);
      chk("playing", 32'(bus_if.playing), e.ply);
`ifdef ENM_HP_SCORE_EN
      chk("score", 32'(bus_if.score), e.score);
`endif
    end
  end

  int k, bx, by, clears;

  initial begin
    bus_if.start = 1'b0; bus_if.bullet_vld = 1'b0;
    bus_if.bullet_x = '0; bus_if.bullet_y = '0;
    ex = '{40, 140, 140, 600};
    ey = '{40, 80, 80, 600};
    clears = 0;

    // Directed opening: reset, idle bullets, start, cooldown, box edges, priority, mid-play reset
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 1, 40, 40);
    drive(0, 1, 0, 0, 0);
    repeat (7) drive(0, 0, 1, 40, 50);
    drive(0, 0, 1, 56, 40);
    drive(0, 0, 1, 55, 40);
    drive(0, 0, 1, 140, 80);
    drive(0, 1, 0, 0, 0);
    drive(1, 0, 1, 140, 80);
    drive(0, 0, 1, 140, 80);
    drive(0, 1, 0, 0, 0);

    // Random phase; enemies are reshuffled periodically and bullets aim near one of them
    for (int t = 0; t < 5000; t++) begin
      if (t % 64 == 0) begin
        for (int i = 0; i < 4; i++) begin
          case ($urandom_range(0, 3))
            0:       begin ex[i] = $urandom_range(0, 20); ey[i] = $urandom_range(1003, 1023); end
            1:       if (i > 0) begin ex[i] = ex[i-1]; ey[i] = ey[i-1]; end
            default: begin ex[i] = $urandom_range(0, 1023); ey[i] = $urandom_range(0, 1023); end
          endcase
        end
      end
      k = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) begin
        bx = ex[k] + (($urandom_range(0, 1) == 1) ? 16 : -16) + int'($urandom_range(0, 1));
        by = ey[k] + int'($urandom_range(0, 30)) - 15;
      end else begin
        bx = ex[k] + int'($urandom_range(0, 40)) - 20;
        by = ey[k] + int'($urandom_range(0, 40)) - 20;
      end
      if (m_st == 2) clears++;
      drive($urandom_range(0, 999) < 3, $urandom_range(0, 19) == 0,
            $urandom_range(0, 9) < 8, bx & 1023, by & 1023);
    end

    drive(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk22);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    chk("clear_reached", 32'(clears > 0), 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
